mem_request_queue: RTL and testbench

- Upstream issue stage for memory_controller: buffers client read and write requests in two independent FIFOs and drives the controller's wr_*/rd_* request ports.
- Per-channel outstanding-request credit counters are decremented by wr_ret_ack/rd_ret_ack. They cap in-flight traffic, because the controller has no back-pressure input.
- Read data returns to the client directly from the controller; this block does not touch rd_ret_data.

---
 rtl/mem_request_queue_pkg.sv | 31 +++
 rtl/mem_request_queue_fifo.sv | 66 ++++++
 rtl/mem_request_queue.sv | 156 +++++++++++++++
 tb/tb_mem_request_queue.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_request_queue_pkg.sv
// mem_request_queue_pkg
// Shared constants and helpers for the memory request queue.
//   ADDR_W_DEF / DATA_W_DEF : default address and write-data widths
//                             (match the memory controller)
//   CNT_W                   : width of the outstanding-request counters
//   credit_next()           : next value of an outstanding-request counter
package mem_request_queue_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 8;

    // An issue takes a credit and an ack returns one. When both happen in
    // the same cycle they cancel. An ack with nothing outstanding is ignored
    // here; the caller flags it.
    function automatic logic [CNT_W-1:0] credit_next(
        input logic [CNT_W-1:0] cnt,
        input logic             issue,
        input logic             ack
    );
        logic [CNT_W-1:0] r;
        r = cnt;
        case ({issue, ack})
            2'b10:   r = cnt + CNT_W'(1);
            2'b01:   r = (cnt == '0) ? cnt : cnt - CNT_W'(1);
            default: r = cnt;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_request_queue_fifo.sv
// req_fifo
// Synchronous FIFO with an asynchronous active-high reset, used for both
// request channels.
// Ports:
//   clk, reset  : clock, async active-high reset (empties the FIFO)
//   push, din   : write din at the tail; ignored while full
//   pop         : drop the head entry; ignored while empty
//   head        : current head entry (valid while !empty)
//   full, empty : status derived from the registered pointers
//   empty_next  : empty as it will be after the coming clock edge
module req_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             empty_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit: same index with different wrap
    // bits means full, identical pointers mean empty.
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_ptr_n, rd_ptr_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign wr_ptr_n   = do_push ? wr_ptr + PW'(1) : wr_ptr;
    assign rd_ptr_n   = do_pop  ? rd_ptr + PW'(1) : rd_ptr;
    assign empty_next = (wr_ptr_n == rd_ptr_n);

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mem_request_queue.sv
// mem_request_queue
// Issue stage in front of the memory controller. Client read and write
// requests are buffered in two independent FIFOs and issued to the
// controller one per cycle. Each channel is limited to MAX_OUT requests
// in flight, tracked by a credit counter that the controller's completion
// acks decrement.
// Ports:
//   clk, reset                        : clock, async active-high reset
//   req_wr_valid/ready/address/data   : client write request channel
//   req_rd_valid/ready/address        : client read request channel
//   wr_en, wr_address, wr_data        : write issue to controller (1-cycle strobe)
//   wr_ret_ack                        : controller write completion
//   rd_en, rd_address                 : read issue to controller (1-cycle strobe)
//   rd_ret_ack                        : controller read completion
//   wr_outstanding, rd_outstanding    : in-flight request counts
//   idle                              : both FIFOs empty, both counts zero
//   err_spurious_ack                  : sticky, an ack arrived with count zero
//
// Handshake: a client request transfers on a rising edge where valid and
// ready are both high. ready depends only on registered state (FIFO not
// full), never on valid or on a same-cycle pop. The client holds valid and
// its payload stable until the transfer happens.
module mem_request_queue
    import mem_request_queue_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_wr_valid,
    output logic              req_wr_ready,
    input  logic [ADDR_W-1:0] req_wr_address,
    input  logic [DATA_W-1:0] req_wr_data,
    input  logic              req_rd_valid,
    output logic              req_rd_ready,
    input  logic [ADDR_W-1:0] req_rd_address,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_address,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ret_ack,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_address,
    input  logic              rd_ret_ack,
    output logic [CNT_W-1:0]  wr_outstanding,
    output logic [CNT_W-1:0]  rd_outstanding,
    output logic              idle,
    output logic              err_spurious_ack
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic [ADDR_W+DATA_W-1:0] wr_head;
    logic [ADDR_W-1:0]        rd_head;
    logic                     wr_full, wr_empty, wr_empty_next;
    logic                     rd_full, rd_empty, rd_empty_next;
    logic                     wr_issue, rd_issue;
    logic [CNT_W-1:0]         wr_cnt_next, rd_cnt_next;
    logic                     wr_spurious, rd_spurious;

    assign req_wr_ready = !wr_full;
    assign req_rd_ready = !rd_full;

    // Issue uses the registered count, so an ack frees its credit only
    // from the following cycle.
    assign wr_issue = !wr_empty && (wr_outstanding < MAX_CNT);
    assign rd_issue = !rd_empty && (rd_outstanding < MAX_CNT);

    assign wr_cnt_next = credit_next(wr_outstanding, wr_issue, wr_ret_ack);
    assign rd_cnt_next = credit_next(rd_outstanding, rd_issue, rd_ret_ack);

    assign err_spurious_ack = wr_spurious || rd_spurious;

    req_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_wr_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (req_wr_valid),
        .pop        (wr_issue),
        .din        ({req_wr_address, req_wr_data}),
        .head       (wr_head),
        .full       (wr_full),
        .empty      (wr_empty),
        .empty_next (wr_empty_next)
    );

    req_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_rd_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (req_rd_valid),
        .pop        (rd_issue),
        .din        (req_rd_address),
        .head       (rd_head),
        .full       (rd_full),
        .empty      (rd_empty),
        .empty_next (rd_empty_next)
    );

    // Write channel: issue register and credit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en          <= 1'b0;
            wr_address     <= '0;
            wr_data        <= '0;
            wr_outstanding <= '0;
            wr_spurious    <= 1'b0;
        end else begin
            wr_en          <= wr_issue;
            wr_outstanding <= wr_cnt_next;
            if (wr_issue) begin
                {wr_address, wr_data} <= wr_head;
            end
            if (wr_ret_ack && !wr_issue && (wr_outstanding == '0)) begin
                wr_spurious <= 1'b1;
            end
        end
    end

    // Read channel: issue register and credit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_en          <= 1'b0;
            rd_address     <= '0;
            rd_outstanding <= '0;
            rd_spurious    <= 1'b0;
        end else begin
            rd_en          <= rd_issue;
            rd_outstanding <= rd_cnt_next;
            if (rd_issue) begin
                rd_address <= rd_head;
            end
            if (rd_ret_ack && !rd_issue && (rd_outstanding == '0)) begin
                rd_spurious <= 1'b1;
            end
        end
    end

    // idle is built from next-state values so that, once registered, it
    // describes the state that exists after each edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle <= 1'b1;
        end else begin
            idle <= wr_empty_next && rd_empty_next &&
                    (wr_cnt_next == '0) && (rd_cnt_next == '0);
        end
    end

endmodule

// File: tb/tb_mem_request_queue.sv
// tb_mem_request_queue
// Directed bench for mem_request_queue (ADDR_W=16, DATA_W=16, DEPTH=4,
// MAX_OUT=2). Issued requests are matched in order against expected queues
// filled when requests are accepted; timing and counter values are checked
// directly at points worked out by hand.
module tb_mem_request_queue;

    logic        clk;
    logic        reset;
    logic        req_wr_valid;
    logic        req_wr_ready;
    logic [15:0] req_wr_address;
    logic [15:0] req_wr_data;
    logic        req_rd_valid;
    logic        req_rd_ready;
    logic [15:0] req_rd_address;
    logic        wr_en;
    logic [15:0] wr_address;
    logic [15:0] wr_data;
    logic        wr_ret_ack;
    logic        rd_en;
    logic [15:0] rd_address;
    logic        rd_ret_ack;
    logic [7:0]  wr_outstanding;
    logic [7:0]  rd_outstanding;
    logic        idle;
    logic        err_spurious_ack;

    int n_vec  = 0;
    int n_miss = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;

    logic [31:0] exp_wr_q[$];
    logic [15:0] exp_rd_q[$];

    mem_request_queue #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .DEPTH   (4),
        .MAX_OUT (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_wr_valid     (req_wr_valid),
        .req_wr_ready     (req_wr_ready),
        .req_wr_address   (req_wr_address),
        .req_wr_data      (req_wr_data),
        .req_rd_valid     (req_rd_valid),
        .req_rd_ready     (req_rd_ready),
        .req_rd_address   (req_rd_address),
        .wr_en            (wr_en),
        .wr_address       (wr_address),
        .wr_data          (wr_data),
        .wr_ret_ack       (wr_ret_ack),
        .rd_en            (rd_en),
        .rd_address       (rd_address),
        .rd_ret_ack       (rd_ret_ack),
        .wr_outstanding   (wr_outstanding),
        .rd_outstanding   (rd_outstanding),
        .idle             (idle),
        .err_spurious_ack (err_spurious_ack)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                wr_pulses++;
                if (exp_wr_q.size() == 0)
                    check_val("wr_unexpected_issue", {wr_address, wr_data}, 32'hFFFF_FFFF);
                else
                    check_val("wr_issue_order", {wr_address, wr_data}, exp_wr_q.pop_front());
            end
            if (rd_en) begin
                rd_pulses++;
                if (exp_rd_q.size() == 0)
                    check_val("rd_unexpected_issue", {16'h0, rd_address}, 32'hFFFF_FFFF);
                else
                    check_val("rd_issue_order", {16'h0, rd_address}, {16'h0, exp_rd_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a write request until it transfers (bounded).
    task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
        logic taken;
        int   waited;
        taken  = 1'b0;
        waited = 0;
        req_wr_valid   = 1'b1;
        req_wr_address = a;
        req_wr_data    = d;
        while (!taken && waited < 30) begin
            taken = req_wr_ready;
            tick();
            waited++;
        end
        req_wr_valid = 1'b0;
        if (taken) exp_wr_q.push_back({a, d});
        else check_val("push_wr_timeout", 32'd0, 32'd1);
    endtask

    task automatic push_rd(input logic [15:0] a);
        logic taken;
        int   waited;
        taken  = 1'b0;
        waited = 0;
        req_rd_valid   = 1'b1;
        req_rd_address = a;
        while (!taken && waited < 30) begin
            taken = req_rd_ready;
            tick();
            waited++;
        end
        req_rd_valid = 1'b0;
        if (taken) exp_rd_q.push_back(a);
        else check_val("push_rd_timeout", 32'd0, 32'd1);
    endtask

    // Ack writes while any are outstanding until the block goes idle.
    task automatic drain_wr();
        int n;
        n = 0;
        while (!idle && n < 60) begin
            wr_ret_ack = (wr_outstanding != 8'd0);
            tick();
            n++;
        end
        wr_ret_ack = 1'b0;
        check_val("drain_wr_idle", {31'd0, idle}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset          = 1'b1;
        req_wr_valid   = 1'b0;
        req_wr_address = '0;
        req_wr_data    = '0;
        req_rd_valid   = 1'b0;
        req_rd_address = '0;
        wr_ret_ack     = 1'b0;
        rd_ret_ack     = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;

        // Reset state
        check_val("rst_idle",     {31'd0, idle},             32'd1);
        check_val("rst_wr_ready", {31'd0, req_wr_ready},     32'd1);
        check_val("rst_rd_ready", {31'd0, req_rd_ready},     32'd1);
        check_val("rst_en",       {30'd0, wr_en, rd_en},     32'd0);
        check_val("rst_counts",   {16'd0, wr_outstanding, rd_outstanding}, 32'd0);
        check_val("rst_err",      {31'd0, err_spurious_ack}, 32'd0);

        // 1. Single write
        tick();
        push_wr(16'h0010, 16'hABCD);                       // accepted at edge 1
        check_val("t1_no_bypass", {31'd0, wr_en}, 32'd0);
        check_val("t1_not_idle",  {31'd0, idle},  32'd0);
        tick();                                             // edge 2: issue
        check_val("t1_wr_en",   {31'd0, wr_en},  32'd1);
        check_val("t1_wr_addr", {16'd0, wr_address}, 32'h0010);
        check_val("t1_wr_data", {16'd0, wr_data},    32'hABCD);
        check_val("t1_wr_out",  {24'd0, wr_outstanding}, 32'd1);
        tick();
        check_val("t1_en_single", {31'd0, wr_en}, 32'd0);
        check_val("t1_addr_hold", {16'd0, wr_address}, 32'h0010);
        wr_ret_ack = 1'b1;
        tick();
        wr_ret_ack = 1'b0;
        check_val("t1_wr_out_ack", {24'd0, wr_outstanding}, 32'd0);
        check_val("t1_idle",       {31'd0, idle},           32'd1);

        // 2. Credit limit on reads
        for (int i = 1; i <= 4; i++) push_rd(16'(i));
        tick();
        tick();
        check_val("t2_rd_out_cap", {24'd0, rd_outstanding}, 32'd2);
        check_val("t2_rd_stalled", {31'd0, rd_en},          32'd0);
        check_val("t2_rd_pulses",  rd_pulses,               32'd2);
        rd_ret_ack = 1'b1;
        tick();                                             // edge n: credit back
        rd_ret_ack = 1'b0;
        check_val("t2_no_issue_on_ack", {31'd0, rd_en},     32'd0);
        check_val("t2_rd_out_ack", {24'd0, rd_outstanding}, 32'd1);
        tick();                                             // edge n+1: 0x3 issues
        check_val("t2_rd_en_3",    {31'd0, rd_en},          32'd1);
        check_val("t2_rd_addr_3",  {16'd0, rd_address},     32'h0003);
        check_val("t2_rd_out_2",   {24'd0, rd_outstanding}, 32'd2);

        // 4. Simultaneous issue and ack at count 1, then spurious ack
        rd_ret_ack = 1'b1;
        tick();                                             // 2 -> 1
        check_val("t4_rd_out_1", {24'd0, rd_outstanding}, 32'd1);
        tick();                                             // issue 0x4 + ack
        rd_ret_ack = 1'b0;
        check_val("t4_issue_ack_en",   {31'd0, rd_en},          32'd1);
        check_val("t4_issue_ack_addr", {16'd0, rd_address},     32'h0004);
        check_val("t4_issue_ack_cnt",  {24'd0, rd_outstanding}, 32'd1);
        rd_ret_ack = 1'b1;
        tick();
        rd_ret_ack = 1'b0;
        check_val("t4_rd_out_0", {24'd0, rd_outstanding}, 32'd0);
        check_val("t4_idle",     {31'd0, idle},           32'd1);
        check_val("t4_no_err",   {31'd0, err_spurious_ack}, 32'd0);
        rd_ret_ack = 1'b1;
        tick();
        rd_ret_ack = 1'b0;
        check_val("t4_err_set",    {31'd0, err_spurious_ack}, 32'd1);
        check_val("t4_cnt_floor",  {24'd0, rd_outstanding},   32'd0);
        tick();
        tick();
        check_val("t4_err_sticky", {31'd0, err_spurious_ack}, 32'd1);

        // 3. Full FIFO with credits exhausted
        for (int i = 0; i < 6; i++) push_wr(16'h0100 + 16'(i), 16'h1000 + 16'(i));
        check_val("t3_wr_full",   {31'd0, req_wr_ready},   32'd0);
        check_val("t3_wr_out_2",  {24'd0, wr_outstanding}, 32'd2);
        req_wr_valid   = 1'b1;
        req_wr_address = 16'h0106;
        req_wr_data    = 16'h1006;
        repeat (3) tick();
        check_val("t3_held_ready", {31'd0, req_wr_ready}, 32'd0);
        wr_ret_ack = 1'b1;
        tick();
        wr_ret_ack = 1'b0;
        check_val("t3_still_full", {31'd0, req_wr_ready}, 32'd0);
        tick();                                             // head issues, slot frees
        check_val("t3_issue_after_ack", {31'd0, wr_en},        32'd1);
        check_val("t3_ready_again",     {31'd0, req_wr_ready}, 32'd1);
        push_wr(16'h0106, 16'h1006);
        drain_wr();
        check_val("t3_all_issued", exp_wr_q.size(), 32'd0);
        check_val("t3_wr_pulses",  wr_pulses,       32'd8);

        // 5. Both channels concurrently
        req_wr_valid   = 1'b1;
        req_wr_address = 16'h0020;
        req_wr_data    = 16'h5A5A;
        req_rd_valid   = 1'b1;
        req_rd_address = 16'h0030;
        exp_wr_q.push_back({16'h0020, 16'h5A5A});
        exp_rd_q.push_back(16'h0030);
        tick();
        req_wr_valid = 1'b0;
        req_rd_valid = 1'b0;
        tick();
        check_val("t5_both_en",  {30'd0, wr_en, rd_en},   32'd3);
        check_val("t5_addrs",    {wr_address, rd_address}, 32'h0020_0030);
        wr_ret_ack = 1'b1;
        rd_ret_ack = 1'b1;
        tick();
        wr_ret_ack = 1'b0;
        rd_ret_ack = 1'b0;
        check_val("t5_idle", {31'd0, idle}, 32'd1);

        // 6. Reset mid-operation: 3 queued, 2 outstanding
        for (int i = 0; i < 5; i++) push_wr(16'h0200 + 16'(i), 16'h2000 + 16'(i));
        check_val("t6_pre_out",  {24'd0, wr_outstanding}, 32'd2);
        check_val("t6_pre_busy", {31'd0, idle},           32'd0);
        #2 reset = 1'b1;
        #1;
        check_val("t6_async_out",   {16'd0, wr_outstanding, rd_outstanding}, 32'd0);
        check_val("t6_async_idle",  {31'd0, idle},             32'd1);
        check_val("t6_async_ready", {30'd0, req_wr_ready, req_rd_ready}, 32'd3);
        check_val("t6_async_en",    {30'd0, wr_en, rd_en},     32'd0);
        check_val("t6_async_err",   {31'd0, err_spurious_ack}, 32'd0);
        check_val("t6_async_addr",  {wr_address, wr_data},     32'd0);
        exp_wr_q.delete();
        exp_rd_q.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        wr_pulses = 0;
        repeat (4) tick();
        check_val("t6_no_issue",   wr_pulses,     32'd0);
        check_val("t6_still_idle", {31'd0, idle}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
